// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clock_meter_pkg;

   localparam int unsigned CNT_W_DEF = 8;

   function automatic int unsigned cnt_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   localparam int unsigned CNT_MAX = cnt_max(CNT_W_DEF);

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StArm     = 2'b01,
      StMeasure = 2'b10
   } state_e;

endpackage

// File: rtl/clock_period_meter_if.sv
// Request/result bundle between a measurement requester and the clock period meter.
interface clock_period_meter_if #(
   parameter int unsigned CNT_W = clock_meter_pkg::CNT_W_DEF
);
   logic             meas_in;
   logic             start;
   logic             busy;
   logic             valid;
   logic             timeout;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;

   modport master (
      output meas_in, start,
      input  busy, valid, timeout, period, high_time
   );

   modport slave (
      input  meas_in, start,
      output busy, valid, timeout, period, high_time
   );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by rise/fall detection.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         hist_q <= sync_out;
      end
   end

   assign rise = sync_out & ~hist_q;
   assign fall = ~sync_out & hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous clock-like input in system clock cycles.
module clock_period_meter
   import clock_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                 clk,
   input logic                 rst,
   clock_period_meter_if.slave bus
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));
   // Timeout fires on the edge where the counter would reach CntMax.
   localparam logic [CNT_W-1:0] CntSat = CNT_W'(cnt_max(CNT_W) - 32'd1);
   localparam logic [CNT_W-1:0] One    = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcap_q, hcap_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             seen_q, seen_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             rise, fall, sat;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.meas_in),
      .rise (rise),
      .fall (fall)
   );

   assign sat = (cnt_q == CntSat);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (bus.start) state_d = StArm;
         StArm:     if (rise) state_d = StMeasure;
                    else if (sat) state_d = StIdle;
         StMeasure: if (rise || sat) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      hcap_d    = hcap_q;
      seen_d    = seen_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               cnt_d     = '0;
               seen_d    = 1'b0;
               valid_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end
         StArm: begin
            if (rise) begin
               cnt_d = One;
            end else if (sat) begin
               period_d  = CntMax;
               high_d    = CntMax;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + One;
            end
         end
         StMeasure: begin
            if (fall && !seen_q) begin
               hcap_d = cnt_q;
               seen_d = 1'b1;
            end
            if (rise) begin
               period_d = cnt_q;
               high_d   = seen_d ? hcap_d : CntMax;
               valid_d  = 1'b1;
            end else if (sat) begin
               period_d  = CntMax;
               high_d    = seen_d ? hcap_d : CntMax;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + One;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         hcap_q    <= '0;
         seen_q    <= 1'b0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hcap_q    <= hcap_d;
         seen_q    <= seen_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.valid     = valid_q;
   assign bus.timeout   = timeout_q;
   assign bus.period    = period_q;
   assign bus.high_time = high_q;

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of an externally generated, asynchronous clock-like signal in units of the system clock. This is the receive end of the divided-clock outputs produced by the clock divide/select block. It runs on the same system clock and confirms on silicon or in simulation that a selected divided clock has the expected ratio. A single measurement is armed by a start pulse; results are held until the next start.

## Interface
Parameters:
- CNT_W, 8, width of period/high-time counters and result registers; saturation value is 2^CNT_W-1.
- SYNC_STAGES, 2, number of synchroniser flops on meas_in (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- meas_in  in  1  signal under measurement; asynchronous to clk.
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE.
- busy  out  1  high in ARM and MEASURE.
- valid  out  1  high from completion of a successful measurement until next start or rst.
- timeout  out  1  high from a timed-out measurement until next start or rst.
- period  out  CNT_W  clk cycles between two consecutive rising edges of meas_in.
- high_time  out  CNT_W  clk cycles from that first rising edge to the following falling edge.

## Operation
- Reset: state=IDLE, counter=0, busy=0, valid=0, timeout=0, period=0, high_time=0, synchroniser and edge-history flops=0.
- Front end: meas_in passes through SYNC_STAGES flops, then one history flop. rise = sync & ~hist; fall = ~sync & hist.
- States:
  - IDLE: on start → ARM; clear valid, timeout and counter in the same cycle. period and high_time keep their old values until overwritten.
  - ARM: counter increments each cycle. On rise → MEASURE with counter=1. If counter reaches 2^CNT_W-1 first → timeout.
  - MEASURE: counter increments each cycle.
    - On the first fall, capture high_time=counter.
    - On rise, load period=counter, set valid=1, and go → IDLE.
    - If counter reaches 2^CNT_W-1 before rise → timeout.
  - Timeout action: period=2^CNT_W-1, high_time=captured value or 2^CNT_W-1 if no fall was seen, timeout=1, valid=0, go → IDLE.
- For a stable input of period P and high time H (P < 2^CNT_W-1): period=P, high_time=H.
- Counter never wraps; saturation is detected by equality, not overflow.
- Rise and saturation in the same cycle: rise wins and the measurement completes normally.
- start while busy: ignored, no effect on state or counter.
- start and rst together: rst wins.
- rst mid-measurement: immediate return to reset values; no partial results are retained.

## Timing
- Edge-detect latency: a meas_in transition is seen as rise/fall SYNC_STAGES+1 clk cycles after it is sampled. This delay is equal for all edges, so period and high_time are unaffected.
- start sampled at edge n: busy=1 and valid/timeout=0 from edge n (visible in cycle n+1).
- Completing rise detected at edge m: period, high_time and valid update at edge m; busy=0 from the same edge.
- Minimum measurable period: 2 clk cycles (1 high, 1 low). Period-1 inputs alias and are not supported.
- Timeout latency from entering a state: 2^CNT_W-1 cycles (255 with defaults).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package clock_meter_pkg holds:
  - state typedef (IDLE, ARM, MEASURE);
  - default CNT_W;
  - saturation constant CNT_MAX = 2^CNT_W-1.
- Sub-module sync_edge_detect (SYNC_STAGES parameter; ports clk, rst, d, rise, fall) contains the synchroniser and edge detection. It is reusable on the other asynchronous inputs of the chip.
- Top level holds the FSM, the counter, the high-time capture flag and the result registers.

## Test plan
- meas_in square wave, 10 clk period, 5 high; start in IDLE → busy 1 then 0; period=10, high_time=5, valid=1, timeout=0.
- Asymmetric input, 3 high / 4 low (divider pattern) → period=7, high_time=3. A second start clears valid for exactly the duration of the new measurement, then gives the same result.
- Minimum input, 1 high / 1 low → period=2, high_time=1.
- Timeouts:
  - meas_in held at 0 → timeout=1, period=255, high_time=255, 255 cycles after ARM entry.
  - meas_in held at 1 after one rise → timeout with high_time=255.
  - Input high 4 then held low → timeout with high_time=4.
- start pulses during MEASURE → ignored; result equals the undisturbed measurement.
- rst asserted mid-MEASURE, asynchronous to clk → all outputs 0 immediately.
  - After release and start with a 12-cycle input → period=12.
